bist_resp_analyzer: RTL

//  Response side of the BIST control interface. Consumes mode/load/capture/done from the

---
 rtl/bist_resp_analyzer.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/bist_resp_analyzer.sv
// BIST response analyzer: compacts DUT output into a MISR and grades signature/pattern count.
// Latency: MISR and count update on the capture edge; result_valid rises one edge after the done edge.
// No backpressure: control inputs are sampled every cycle, illegal sequences set the sticky proto_err.
module bist_resp_analyzer #(
    parameter int               WIDTH      = 16,
    parameter logic [WIDTH-1:0] POLY       = 16'h100B,
    parameter logic [WIDTH-1:0] MISR_SEED  = 16'h0000,
    parameter logic [WIDTH-1:0] GOLDEN_SIG = 16'h0000,
    parameter int               N_PATTERNS = 256,
    parameter int               CNT_W      = 9
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             mode,
    input  logic             load,
    input  logic             capture,
    input  logic             done,
    input  logic [WIDTH-1:0] dut_out,
    output logic [WIDTH-1:0] signature,
    output logic [CNT_W-1:0] pattern_cnt,
    output logic             busy,
    output logic             result_valid,
    output logic             pass,
    output logic             fail,
    output logic             proto_err
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ARMED,
        S_COMPACT,
        S_CHECK,
        S_REPORT
    } state_t;

    localparam logic [CNT_W-1:0] N_PAT_C = CNT_W'(N_PATTERNS);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] sig_q, sig_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             busy_q, busy_d;
    logic             rv_q, rv_d;
    logic             pass_q, pass_d;
    logic             fail_q, fail_d;
    logic             perr_q, perr_d;

    logic [WIDTH-1:0] misr_next;
    logic [CNT_W-1:0] cnt_inc;
    logic             grade_ok;

    assign misr_next = {sig_q[WIDTH-2:0], 1'b0} ^ (sig_q[WIDTH-1] ? POLY : '0) ^ dut_out;
    assign cnt_inc   = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;
    // A saturated counter can never equal N_PATTERNS, so saturation grades as fail.
    assign grade_ok  = (sig_q == GOLDEN_SIG) && (cnt_q == N_PAT_C);

    always_comb begin
        state_d = state_q;
        sig_d   = sig_q;
        cnt_d   = cnt_q;
        rv_d    = rv_q;
        pass_d  = pass_q;
        fail_d  = fail_q;
        perr_d  = perr_q;

        if (load && mode) begin
            state_d = S_ARMED;
            sig_d   = MISR_SEED;
            cnt_d   = '0;
            rv_d    = 1'b0;
            pass_d  = 1'b0;
            fail_d  = 1'b0;
            perr_d  = 1'b0;
        end else begin
            if (capture && !mode) begin
                perr_d = 1'b1;
            end
            unique case (state_q)
                S_IDLE: begin
                    if (capture || done) begin
                        perr_d = 1'b1;
                    end
                end
                S_ARMED, S_COMPACT: begin
                    if (!mode) begin
                        state_d = S_IDLE;
                    end else begin
                        if (capture) begin
                            sig_d   = misr_next;
                            cnt_d   = cnt_inc;
                            state_d = S_COMPACT;
                        end
                        if (done) begin
                            state_d = S_CHECK;
                        end
                    end
                end
                S_CHECK: begin
                    if (!mode) begin
                        state_d = S_IDLE;
                    end else begin
                        pass_d  = grade_ok;
                        fail_d  = !grade_ok;
                        rv_d    = 1'b1;
                        state_d = S_REPORT;
                    end
                end
                S_REPORT: begin
                    if (capture) begin
                        perr_d = 1'b1;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end

        busy_d = (state_d == S_ARMED) || (state_d == S_COMPACT) || (state_d == S_CHECK);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            sig_q   <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            rv_q    <= 1'b0;
            pass_q  <= 1'b0;
            fail_q  <= 1'b0;
            perr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sig_q   <= sig_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            rv_q    <= rv_d;
            pass_q  <= pass_d;
            fail_q  <= fail_d;
            perr_q  <= perr_d;
        end
    end

    assign signature    = sig_q;
    assign pattern_cnt  = cnt_q;
    assign busy         = busy_q;
    assign result_valid = rv_q;
    assign pass         = pass_q;
    assign fail         = fail_q;
    assign proto_err    = perr_q;

endmodule
